// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit for the RV32 datapath.
// A single 32-bit adder is shared by the shift-add multiply steps and the
// shift-subtract (restoring) divide steps. Each operation takes 32 steps.
// Valid/ready handshakes are used on both the request side and the result side.

module adder_bit32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] full;

  // Subtraction is a + ~b + 1. In that case cout=1 means no borrow (a >= b).
  always_comb begin
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
    sum  = full[31:0];
    cout = full[32];
  end
endmodule

module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            busy
);
  localparam int unsigned CW = $clog2(STEPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier->product low half / quotient
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] res_data_q, res_data_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_sub, add_cout;

  adder_bit32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Adder operand steering. Operands are only meaningful in RUN and are held at zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == S_RUN) begin
      if (!op_q[1]) begin
        add_a = hi_q;
        add_b = lo_q[0] ? opnd_q : '0;
      end else begin
        add_a   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        add_b   = opnd_q;
        add_sub = 1'b1;
      end
    end
  end

  // Next-state logic for the sequencer, the datapath and the registered outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d  = req_op;
          cnt_d = '0;
          if (req_op[1]) begin
            opnd_d  = req_b;
            hi_d    = '0;
            lo_d    = req_a;
            state_d = S_RUN;
            // Divide by zero skips the iterations. The RISC-V results are preloaded directly.
            if (req_b == '0) begin
              hi_d    = req_a;
              lo_d    = '1;
              state_d = S_DONE;
            end
          end else begin
            opnd_d  = req_a;
            hi_d    = '0;
            lo_d    = req_b;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!op_q[1]) begin
          hi_d = {add_cout, add_sum[XLEN-1:1]};
          lo_d = {add_sum[0], lo_q[XLEN-1:1]};
        end else if (hi_q[XLEN-1] || add_cout) begin
          hi_d = add_sum;
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = add_a;
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        // The first DONE cycle registers the result. The handshake completes only after valid is visible.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = op_q[0] ? hi_q : lo_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq. The expected results are computed by hand.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;

  muldiv_seq #(.XLEN(32), .STEPS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one request, waits for the result, checks the latency and the data, then consumes the result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp);
    int n;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hDEAD_BEEF;
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, res_data, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("mul_7x6",    OP_MUL,   32'd7, 32'd6, 33, 32'd42);
    do_op("mulhu_7x6",  OP_MULHU, 32'd7, 32'd6, 33, 32'd0);
    do_op("mulhu_ff",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    do_op("mul_ff",     OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001);
    do_op("mul_shift",  OP_MUL,   32'h1234_5678, 32'h10, 33, 32'h2345_6780);
    do_op("mulhu_shift",OP_MULHU, 32'h1234_5678, 32'h10, 33, 32'h0000_0001);
    do_op("divu_100_7", OP_DIVU,  32'd100, 32'd7, 33, 32'd14);
    do_op("remu_100_7", OP_REMU,  32'd100, 32'd7, 33, 32'd2);
    do_op("divu_ff_1",  OP_DIVU,  32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF);
    do_op("remu_ff_1",  OP_REMU,  32'hFFFF_FFFF, 32'd1, 33, 32'd0);
    do_op("divu_big",   OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 33, 32'd1);
    do_op("remu_big",   OP_REMU,  32'hFFFF_FFFF, 32'h8000_0001, 33, 32'h7FFF_FFFE);
    do_op("divu_zero",  OP_DIVU,  32'h1234, 32'd0, 1, 32'hFFFF_FFFF);
    do_op("remu_zero",  OP_REMU,  32'h1234, 32'd0, 1, 32'h0000_1234);

    // Backpressure in DONE, plus a second request raised while the unit is running.
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd9; req_b = 32'd5;
    tick();
    req_op = OP_DIVU; req_a = 32'd50; req_b = 32'd3;
    tick();
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_no_ready", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    check("bp_lat", 32'(n), 32'd32);
    check("bp_data", res_data, 32'd45);
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", {31'd0, res_valid}, 32'd1);
      check("bp_data_hold", res_data, held);
      check("bp_no_ready", {31'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_release", {31'd0, res_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_idle_busy", {31'd0, busy}, 32'd0);

    // Reset while running: the operation is aborted and no result appears afterwards.
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd4;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", res_data, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) n++;
    end
    check("abort_no_result", 32'(n), 32'd0);
    do_op("post_abort", OP_REMU, 32'd1000, 32'd13, 33, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
